seg7_scan_driver: RTL

//  Consumer end of the display-select path: takes the selected 32-bit word and drives
//  the board's 8-digit multiplexed 7-segment display as 8 hex digits.
//  - Time-multiplexes the digits with a programmable slot period and an anode dead time.
//  - Snapshots the word once per frame, so a changing CPU value never tears mid-frame.
//  - Optional leading-zero blanking and per-digit decimal points.

---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg7_hex_dec.sv | 13 +
 rtl/seg7_scan_driver.sv | 112 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and hex->segment table for the 7-segment scan driver.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: SEG_BLANK / AN_OFF idle patterns, seg7_hex() nibble decode.
package seg7_pkg;

    // All segments dark ({g,f,e,d,c,b,a}, active low).
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    // All digit anodes disabled (active low).
    localparam logic [7:0] AN_OFF    = 8'hFF;

    // Active-low segment pattern for one hex nibble, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7_hex(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex nibble to active-low 7-segment pattern.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
// Ports: nibble (4, in) hex digit; seg (7, out) {g,f,e,d,c,b,a} active low.
module seg7_hex_dec (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    import seg7_pkg::*;

    assign seg = seg7_hex(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Scans a 32-bit word onto an 8-digit multiplexed 7-segment display as hex.
// Latency: outputs registered, lagging the slot counter/digit index by 1 cycle.
// Backpressure: none; value is snapshotted once per frame, freeze holds snapshot.
// Ports: clk, rst_n (async, active low); value[31:0] word to show; dp[7:0] live
//        decimal points; blank_lz leading-zero blanking; freeze hold snapshot;
//        an[7:0]/seg[6:0]/dp_n active-low display drives; frame_done 1-cycle pulse.
module seg7_scan_driver #(
    parameter int DIV_CNT    = 100000,
    parameter int DEAD_CYC   = 2,
    parameter int NUM_DIGITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] value,
    input  logic [7:0]  dp,
    input  logic        blank_lz,
    input  logic        freeze,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        frame_done
);
    import seg7_pkg::*;

    localparam int CNT_W = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      shadow_q, shadow_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_n_q, dp_n_d;
    logic             frame_done_q, frame_done_d;

    logic             slot_end;
    logic             frame_end;
    logic             dead;
    logic             lz_blank;
    logic [31:0]      upper;
    logic [3:0]       cur_nib;
    logic [6:0]       dec_seg;

    assign slot_end  = (cnt_q == CNT_W'(DIV_CNT - 1));
    assign frame_end = slot_end && (idx_q == 3'(NUM_DIGITS - 1));

    // Signed compare keeps DEAD_CYC=0 a clean "never dead" case.
    assign dead = (int'(cnt_q) < DEAD_CYC);

    // Current digit and everything above it; all-zero above means a leading zero.
    assign upper    = shadow_q >> {idx_q, 2'b00};
    assign cur_nib  = upper[3:0];
    assign lz_blank = blank_lz && (idx_q != 3'd0) && (upper == 32'd0);

    seg7_hex_dec u_hex_dec (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    // Slot counter, digit index and frame snapshot.
    always_comb begin
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        frame_done_d = frame_end;
        if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
        end
        // freeze only matters at the boundary, so mid-frame toggles are inert.
        if (frame_end && !freeze) begin
            shadow_d = value;
        end
    end

    // Display drive; blanking (dead time or leading zero) overrides dp.
    always_comb begin
        an_d   = AN_OFF;
        seg_d  = SEG_BLANK;
        dp_n_d = 1'b1;
        if (!dead && !lz_blank) begin
            an_d   = ~(8'b1 << idx_q);
            seg_d  = dec_seg;
            dp_n_d = ~dp[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            shadow_q     <= 32'd0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_BLANK;
            dp_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_n_q       <= dp_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp_n       = dp_n_q;
    assign frame_done = frame_done_q;

endmodule
